// File: rtl/gray_seq_if.sv
// Handshake and status bundle between a run sequencer and gray_seq_ctrl.
// master: sequencer side (drives start_valid/start_len/pause/stop/clr).
// slave:  controller side (drives start_ready, gray_cnt and the status pulses).
interface gray_seq_if #(
  parameter int CBITS = 18,
  parameter int LEN_W = 18
);
  logic             start_valid;
  logic             start_ready;
  logic [LEN_W-1:0] start_len;
  logic             pause;
  logic             stop;
  logic             clr;
  logic [CBITS-1:0] gray_cnt;
  logic             gray_vld;
  logic             wrap;
  logic             done;
  logic             busy;
  logic             err;

  modport master (
    output start_valid, start_len, pause, stop, clr,
    input  start_ready, gray_cnt, gray_vld, wrap, done, busy, err
  );

  modport slave (
    input  start_valid, start_len, pause, stop, clr,
    output start_ready, gray_cnt, gray_vld, wrap, done, busy, err
  );
endinterface

// File: rtl/gray_seq_ctrl.sv
// Run controller for a binary-backed Gray counter: steps it start_len times (0 = until stop).
// Latency: first step one edge after the start handshake; gray_vld/wrap registered, done during DONE.
// Backpressure: start_ready high only in IDLE; pause freezes stepping, stop aborts the run.
// Ports: clk, rst (async, active-high); bus (gray_seq_if.slave): start_valid/start_ready/start_len,
//   pause, stop, clr in; gray_cnt, gray_vld, wrap, done, busy, err out.
// Optional: define GRAY_SEQ_CHK_EN to build the Gray single-bit-step checker driving err.
module gray_seq_ctrl #(
  parameter int CBITS = 18,
  parameter int LEN_W = 18
) (
  input  logic      clk,
  input  logic      rst,
  gray_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CBITS-1:0] cnt;
  logic [CBITS-1:0] gray_q;
  logic [CBITS-1:0] cnt_inc;
  logic [CBITS-1:0] gray_inc;
  logic [LEN_W-1:0] remaining;
  logic             step;
  logic             gray_vld_q;
  logic             wrap_q;
  logic             accept;
  logic             clr_now;

  // stop outranks pause, pause outranks the step
  always_comb begin
    step     = (state == S_RUN) && !bus.stop && !bus.pause;
    accept   = (state == S_IDLE) && bus.start_valid;
    clr_now  = (state == S_IDLE) && bus.clr;
    cnt_inc  = cnt + CBITS'(1);
    gray_inc = cnt_inc ^ (cnt_inc >> 1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.start_valid) state_nxt = S_RUN;
      S_RUN: begin
        if (bus.stop)                         state_nxt = S_DONE;
        else if (bus.pause)                   state_nxt = S_HOLD;
        // remaining loaded as 0 never reaches 1, so free-run only ends on stop
        else if (remaining == LEN_W'(1))      state_nxt = S_DONE;
      end
      S_HOLD: begin
        if (bus.stop)        state_nxt = S_DONE;
        else if (!bus.pause) state_nxt = S_RUN;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      gray_q     <= '0;
      remaining  <= '0;
      gray_vld_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      gray_vld_q <= step;
      wrap_q     <= step && (cnt_inc == '0);
      // cnt and gray_q always move together so gray_q == gray(cnt) holds every cycle;
      // clr and step are exclusive (IDLE vs RUN) so the order here is only cosmetic
      if (clr_now) begin
        cnt    <= '0;
        gray_q <= '0;
      end else if (step) begin
        cnt    <= cnt_inc;
        gray_q <= gray_inc;
      end
      if (accept) begin
        remaining <= bus.start_len;
      end else if (step && (remaining != '0)) begin
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

  assign bus.start_ready = (state == S_IDLE);
  assign bus.busy        = (state == S_RUN) || (state == S_HOLD);
  assign bus.done        = (state == S_DONE);
  assign bus.gray_cnt    = gray_q;
  assign bus.gray_vld    = gray_vld_q;
  assign bus.wrap        = wrap_q;

`ifdef GRAY_SEQ_CHK_EN
  logic [CBITS-1:0] gray_diff;
  logic             step_bad;
  logic             err_q;

  // a legal Gray step flips exactly one bit: diff is non-zero and a power of two
  always_comb begin
    gray_diff = gray_q ^ gray_inc;
    step_bad  = (gray_diff == '0) || ((gray_diff & (gray_diff - CBITS'(1))) != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (step && step_bad) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_seq_ctrl.sv
module tb_gray_seq_ctrl;
  localparam int CB = 4;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gray_seq_if #(.CBITS(CB), .LEN_W(LW)) bus ();
  gray_seq_ctrl #(.CBITS(CB), .LEN_W(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct { logic [3:0] gray; logic wrap; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int   mdl_cnt = 0;

  typedef struct {
    logic       clr;
    logic [7:0] len;
    int         steps;
    logic [3:0] fin;
    int         wraps;
  } row_t;
  row_t rows[5];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] gray_of(input int n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic push_steps(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      mdl_cnt = (mdl_cnt + 1) % 16;
      e.gray = gray_of(mdl_cnt);
      e.wrap = (mdl_cnt == 0);
      sbq.push_back(e);
    end
  endtask

  // scoreboard consumer plus per-cycle status consistency
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.gray_vld) begin
        if (sbq.size() == 0) check("unexpected_step", 1, 0);
        else begin
          mon_e = sbq.pop_front();
          check("sb_gray", int'(bus.gray_cnt), int'(mon_e.gray));
          check("sb_wrap", int'(bus.wrap), int'(mon_e.wrap));
        end
      end else begin
        check("wrap_without_step", int'(bus.wrap), 0);
      end
      check("ready_iff_idle", int'(bus.start_ready), int'(!bus.busy && !bus.done));
      check("err_clear", int'(bus.err), 0);
    end
  end

  task automatic wait_ready();
    for (int k = 0; k < 50 && !bus.start_ready; k++) @(negedge clk);
    check("ready_wait", int'(bus.start_ready), 1);
  endtask

  task automatic start_run(input logic c, input logic [7:0] len);
    wait_ready();
    bus.start_valid = 1'b1;
    bus.start_len   = len;
    bus.clr         = c;
    @(negedge clk);
    bus.start_valid = 1'b0;
    bus.clr         = 1'b0;
  endtask

  task automatic do_clr();
    wait_ready();
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    mdl_cnt = 0;
    check("clr_zero", int'(bus.gray_cnt), 0);
  endtask

  task automatic run_row(input int idx);
    int steps = 0;
    int wraps = 0;
    bit seen  = 0;
    if (rows[idx].clr) mdl_cnt = 0;
    push_steps(int'(rows[idx].len));
    start_run(rows[idx].clr, rows[idx].len);
    for (int c = 0; c < 600; c++) begin
      if (bus.gray_vld) steps++;
      if (bus.wrap) wraps++;
      if (bus.done) begin seen = 1; break; end
      @(negedge clk);
    end
    check($sformatf("row%0d_done_seen", idx), int'(seen), 1);
    check($sformatf("row%0d_steps", idx), steps, rows[idx].steps);
    check($sformatf("row%0d_wraps", idx), wraps, rows[idx].wraps);
    check($sformatf("row%0d_final_gray", idx), int'(bus.gray_cnt), int'(rows[idx].fin));
    @(negedge clk);
    check($sformatf("row%0d_done_one_cycle", idx), int'(bus.done), 0);
    check($sformatf("row%0d_ready_after", idx), int'(bus.start_ready), 1);
    check($sformatf("row%0d_sb_empty", idx), sbq.size(), 0);
  endtask

  initial begin
    int  n;
    int  w;
    int  early;
    bit  seen;
    bit  paused;

    rows[0] = '{clr: 1'b0, len: 8'd5,   steps: 5,   fin: 4'd7,  wraps: 0};
    rows[1] = '{clr: 1'b0, len: 8'd4,   steps: 4,   fin: 4'd13, wraps: 0};
    rows[2] = '{clr: 1'b1, len: 8'd2,   steps: 2,   fin: 4'd3,  wraps: 0};
    rows[3] = '{clr: 1'b0, len: 8'd15,  steps: 15,  fin: 4'd1,  wraps: 1};
    rows[4] = '{clr: 1'b0, len: 8'd200, steps: 200, fin: 4'd13, wraps: 12};

    rst = 1'b1;
    bus.start_valid = 1'b0;
    bus.start_len   = '0;
    bus.pause       = 1'b0;
    bus.stop        = 1'b0;
    bus.clr         = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gray", int'(bus.gray_cnt), 0);
    check("rst_vld", int'(bus.gray_vld), 0);
    check("rst_wrap", int'(bus.wrap), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_ready", int'(bus.start_ready), 1);
    rst = 1'b0;
    @(negedge clk);

    // rows 0..2: len 5 from 0, len 4 to cnt 9, then clr+start with len 2
    for (int i = 0; i < 5; i++) run_row(i);

    // free-run for 17 steps, then stop
    do_clr();
    push_steps(17);
    start_run(1'b0, 8'd0);
    n = 0; w = 0; early = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.gray_vld) n++;
      if (bus.wrap) w++;
      if (bus.done) early++;
      if (n == 17) begin bus.stop = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus.stop = 1'b0;
    check("fr_steps", n, 17);
    check("fr_wraps", w, 1);
    check("fr_no_early_done", early, 0);
    check("fr_done_after_stop", int'(bus.done), 1);
    check("fr_no_step_on_stop", int'(bus.gray_vld), 0);
    @(negedge clk);
    check("fr_done_one_cycle", int'(bus.done), 0);
    check("fr_ready", int'(bus.start_ready), 1);

    // pause for 3 cycles after the 2nd step of a 6-step run
    do_clr();
    push_steps(6);
    start_run(1'b0, 8'd6);
    n = 0; seen = 0; paused = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.gray_vld) n++;
      if (bus.done) begin seen = 1; break; end
      if (n == 2 && !paused) begin
        paused = 1;
        bus.pause = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("pause_no_step", int'(bus.gray_vld), 0);
          check("pause_hold", int'(bus.gray_cnt), 3);
        end
        bus.pause = 1'b0;
      end
      @(negedge clk);
    end
    check("pause_done", int'(seen), 1);
    check("pause_total_steps", n, 6);
    @(negedge clk);

    // stop and pause together during RUN (cnt 6 -> 8 after 2 steps)
    push_steps(2);
    start_run(1'b0, 8'd10);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.gray_vld) n++;
      if (n == 2) begin bus.stop = 1'b1; bus.pause = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus.stop = 1'b0;
    bus.pause = 1'b0;
    check("sp_steps", n, 2);
    check("sp_done", int'(bus.done), 1);
    check("sp_no_step", int'(bus.gray_vld), 0);
    check("sp_gray_held", int'(bus.gray_cnt), 12);
    @(negedge clk);
    check("sp_done_one_cycle", int'(bus.done), 0);
    check("sp_ready", int'(bus.start_ready), 1);

    // reset after 3 steps of a 10-step run
    do_clr();
    push_steps(3);
    start_run(1'b0, 8'd10);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.gray_vld) n++;
      if (n == 3) break;
      @(negedge clk);
    end
    check("rr_steps", n, 3);
    #2 rst = 1'b1;
    #1;
    check("rr_gray", int'(bus.gray_cnt), 0);
    check("rr_vld", int'(bus.gray_vld), 0);
    check("rr_wrap", int'(bus.wrap), 0);
    check("rr_done", int'(bus.done), 0);
    check("rr_busy", int'(bus.busy), 0);
    check("rr_ready", int'(bus.start_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    mdl_cnt = 0;
    sbq.delete();
    early = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done || bus.gray_vld) early++;
    end
    check("rr_quiet_after", early, 0);
    check("rr_idle", int'(bus.start_ready), 1);
    check("final_sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
